// File: rtl/ysyx_23060077_lsu_axi_master_if.sv
// AXI4 master-side bus bundle (single-beat, one ID) used between the LSU bridge
// and the core bus arbiter.
//   master modport: drives AR/AW/W valids and payloads, R/B readies.
//   slave  modport: drives AR/AW/W readies, R/B valids and payloads.
interface ysyx_23060077_lsu_axi_master_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    // read address channel
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;

    // read data channel
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    // write address channel
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;

    // write data channel
    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;

    // write response channel
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast,
        output rready,
        output awvalid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast,
        input  rready,
        input  awvalid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp,
        input  bready
    );
endinterface

// File: rtl/ysyx_23060077_lsu_axi_master.sv
// LSU -> AXI4 master bridge. Accepts one load or store from the LSU at a time,
// issues it as a single-beat AXI transaction, aligns byte lanes in both
// directions and returns a one-cycle completion pulse.
//
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   lsu_r_*                 : load request (valid/addr/len) and completion (ready/last/data)
//   lsu_w_*                 : store request (valid/addr/data/len/size) and completion (ready/last)
//   axi                     : AXI4 master bundle (AR, R, AW, W, B)
// Optional (macro YSYX_23060077_LSU_AXI_ERR_EN):
//   lsu_bus_err_o           : pulses with the completion when rresp/bresp != OKAY
//   lsu_err_addr_o          : latched address of the most recent faulting access
//
// All outputs are registered; each output register is loaded from the value
// the combinational process computes for the next state.
module ysyx_23060077_lsu_axi_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  lsu_r_valid_i,
    input  logic [ADDR_WIDTH-1:0] lsu_r_addr_i,
    input  logic [7:0]            lsu_r_len_i,
    output logic                  lsu_r_ready_o,
    output logic                  lsu_r_last_o,
    output logic [DATA_WIDTH-1:0] lsu_r_data_o,

    input  logic                  lsu_w_valid_i,
    input  logic [ADDR_WIDTH-1:0] lsu_w_addr_i,
    input  logic [DATA_WIDTH-1:0] lsu_w_data_i,
    input  logic [7:0]            lsu_w_len_i,
    input  logic [2:0]            lsu_w_size_i,
    output logic                  lsu_w_ready_o,
    output logic                  lsu_w_last_o,

`ifdef YSYX_23060077_LSU_AXI_ERR_EN
    output logic                  lsu_bus_err_o,
    output logic [ADDR_WIDTH-1:0] lsu_err_addr_o,
`endif

    ysyx_23060077_lsu_axi_master_if.master axi
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        RDONE,
        WADDR,
        WRESP,
        WDONE
    } state_e;

    state_e state_q, state_d;

    logic                  arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0] araddr_q,  araddr_d;
    logic [7:0]            arlen_q,   arlen_d;
    logic [2:0]            arsize_q,  arsize_d;
    logic [1:0]            arburst_q, arburst_d;
    logic                  rready_q,  rready_d;

    logic                  awvalid_q, awvalid_d;
    logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
    logic [7:0]            awlen_q,   awlen_d;
    logic [2:0]            awsize_q,  awsize_d;
    logic [1:0]            awburst_q, awburst_d;
    logic                  wvalid_q,  wvalid_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q,   wstrb_d;
    logic                  wlast_q,   wlast_d;
    logic                  bready_q,  bready_d;

    logic                  r_cpl_q,   r_cpl_d;
    logic                  w_cpl_q,   w_cpl_d;
    logic [DATA_WIDTH-1:0] r_data_q,  r_data_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q,  w_done_d;

`ifdef YSYX_23060077_LSU_AXI_ERR_EN
    logic                  bus_err_q,  bus_err_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
`else
    // responses are deliberately ignored in this build
    logic unused_resp;
    assign unused_resp = ^{axi.rresp, axi.bresp};
`endif

    // Store size decode: anything above word is treated as word.
    logic [2:0]            wr_size;
    logic [STRB_WIDTH-1:0] wr_strb_base;
    logic [STRB_WIDTH-1:0] wr_strb_sh;
    logic [DATA_WIDTH-1:0] wr_data_sh;
    logic [DATA_WIDTH-1:0] rd_data_sh;

    assign wr_size = (lsu_w_size_i >= 3'd2) ? 3'd2 : lsu_w_size_i;

    always_comb begin
        wr_strb_base = STRB_WIDTH'(15);
        case (wr_size)
            3'd0:    wr_strb_base = STRB_WIDTH'(1);
            3'd1:    wr_strb_base = STRB_WIDTH'(3);
            default: wr_strb_base = STRB_WIDTH'(15);
        endcase
    end

    // Lane shifts; strobe bits pushed past the top lane are simply dropped.
    assign wr_strb_sh = wr_strb_base << lsu_w_addr_i[1:0];
    assign wr_data_sh = lsu_w_data_i << {lsu_w_addr_i[1:0], 3'b000};
    assign rd_data_sh = axi.rdata >> {addr_lo_q, 3'b000};

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;

        arvalid_d  = 1'b0;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        arsize_d   = arsize_q;
        arburst_d  = arburst_q;
        rready_d   = 1'b0;

        awvalid_d  = 1'b0;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        awsize_d   = awsize_q;
        awburst_d  = awburst_q;
        wvalid_d   = 1'b0;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wlast_d    = 1'b0;
        bready_d   = 1'b0;

        r_cpl_d    = 1'b0;
        w_cpl_d    = 1'b0;
        r_data_d   = r_data_q;
        addr_lo_d  = addr_lo_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;

`ifdef YSYX_23060077_LSU_AXI_ERR_EN
        bus_err_d  = 1'b0;
        err_addr_d = err_addr_q;
        lat_addr_d = lat_addr_q;
`endif

        case (state_q)
            IDLE: begin
                // read wins when both requests are present
                if (lsu_r_valid_i) begin
                    state_d   = RADDR;
                    arvalid_d = 1'b1;
                    araddr_d  = {lsu_r_addr_i[ADDR_WIDTH-1:2], 2'b00};
                    arlen_d   = lsu_r_len_i;
                    arsize_d  = 3'b010;
                    arburst_d = 2'b01;
                    addr_lo_d = lsu_r_addr_i[1:0];
`ifdef YSYX_23060077_LSU_AXI_ERR_EN
                    lat_addr_d = lsu_r_addr_i;
`endif
                end else if (lsu_w_valid_i) begin
                    state_d   = WADDR;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    wlast_d   = 1'b1;
                    awaddr_d  = {lsu_w_addr_i[ADDR_WIDTH-1:2], 2'b00};
                    awlen_d   = lsu_w_len_i;
                    awsize_d  = wr_size;
                    awburst_d = 2'b01;
                    wdata_d   = wr_data_sh;
                    wstrb_d   = wr_strb_sh;
                    addr_lo_d = lsu_w_addr_i[1:0];
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
`ifdef YSYX_23060077_LSU_AXI_ERR_EN
                    lat_addr_d = lsu_w_addr_i;
`endif
                end
            end

            RADDR: begin
                if (arvalid_q && axi.arready) begin
                    state_d  = RDATA;
                    rready_d = 1'b1;
                end else begin
                    arvalid_d = 1'b1;
                end
            end

            RDATA: begin
                if (axi.rvalid && axi.rlast) begin
                    state_d  = RDONE;
                    r_cpl_d  = 1'b1;
                    r_data_d = rd_data_sh;
`ifdef YSYX_23060077_LSU_AXI_ERR_EN
                    if (axi.rresp != 2'b00) begin
                        bus_err_d  = 1'b1;
                        err_addr_d = lat_addr_q;
                    end
`endif
                end else begin
                    rready_d = 1'b1;
                end
            end

            RDONE: begin
                state_d = IDLE;
            end

            WADDR: begin
                // AW and W complete independently; same-cycle completion is fine
                aw_done_d = aw_done_q | (awvalid_q & axi.awready);
                w_done_d  = w_done_q  | (wvalid_q  & axi.wready);
                if (aw_done_d && w_done_d) begin
                    state_d  = WRESP;
                    bready_d = 1'b1;
                end else begin
                    awvalid_d = ~aw_done_d;
                    wvalid_d  = ~w_done_d;
                    wlast_d   = ~w_done_d;
                end
            end

            WRESP: begin
                if (axi.bvalid) begin
                    state_d = WDONE;
                    w_cpl_d = 1'b1;
`ifdef YSYX_23060077_LSU_AXI_ERR_EN
                    if (axi.bresp != 2'b00) begin
                        bus_err_d  = 1'b1;
                        err_addr_d = lat_addr_q;
                    end
`endif
                end else begin
                    bready_d = 1'b1;
                end
            end

            WDONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            arsize_q   <= '0;
            arburst_q  <= '0;
            rready_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            awaddr_q   <= '0;
            awlen_q    <= '0;
            awsize_q   <= '0;
            awburst_q  <= '0;
            wvalid_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wlast_q    <= 1'b0;
            bready_q   <= 1'b0;
            r_cpl_q    <= 1'b0;
            w_cpl_q    <= 1'b0;
            r_data_q   <= '0;
            addr_lo_q  <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
`ifdef YSYX_23060077_LSU_AXI_ERR_EN
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
            lat_addr_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            arvalid_q  <= arvalid_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            arsize_q   <= arsize_d;
            arburst_q  <= arburst_d;
            rready_q   <= rready_d;
            awvalid_q  <= awvalid_d;
            awaddr_q   <= awaddr_d;
            awlen_q    <= awlen_d;
            awsize_q   <= awsize_d;
            awburst_q  <= awburst_d;
            wvalid_q   <= wvalid_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wlast_q    <= wlast_d;
            bready_q   <= bready_d;
            r_cpl_q    <= r_cpl_d;
            w_cpl_q    <= w_cpl_d;
            r_data_q   <= r_data_d;
            addr_lo_q  <= addr_lo_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
`ifdef YSYX_23060077_LSU_AXI_ERR_EN
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
            lat_addr_q <= lat_addr_d;
`endif
        end
    end

    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = arlen_q;
    assign axi.arsize  = arsize_q;
    assign axi.arburst = arburst_q;
    assign axi.rready  = rready_q;
    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = awaddr_q;
    assign axi.awlen   = awlen_q;
    assign axi.awsize  = awsize_q;
    assign axi.awburst = awburst_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = wlast_q;
    assign axi.bready  = bready_q;

    assign lsu_r_ready_o = r_cpl_q;
    assign lsu_r_last_o  = r_cpl_q;
    assign lsu_r_data_o  = r_data_q;
    assign lsu_w_ready_o = w_cpl_q;
    assign lsu_w_last_o  = w_cpl_q;

`ifdef YSYX_23060077_LSU_AXI_ERR_EN
    assign lsu_bus_err_o  = bus_err_q;
    assign lsu_err_addr_o = err_addr_q;
`endif

endmodule

// File: tb/tb_ysyx_23060077_lsu_axi_master.sv
// Directed bench for the LSU -> AXI bridge with a configurable-latency AXI slave.
module tb_ysyx_23060077_lsu_axi_master;

    logic        clk;
    logic        reset;

    logic        lsu_r_valid_i;
    logic [31:0] lsu_r_addr_i;
    logic [7:0]  lsu_r_len_i;
    logic        lsu_r_ready_o;
    logic        lsu_r_last_o;
    logic [31:0] lsu_r_data_o;
    logic        lsu_w_valid_i;
    logic [31:0] lsu_w_addr_i;
    logic [31:0] lsu_w_data_i;
    logic [7:0]  lsu_w_len_i;
    logic [2:0]  lsu_w_size_i;
    logic        lsu_w_ready_o;
    logic        lsu_w_last_o;
`ifdef YSYX_23060077_LSU_AXI_ERR_EN
    logic        lsu_bus_err_o;
    logic [31:0] lsu_err_addr_o;
`endif

    ysyx_23060077_lsu_axi_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    ysyx_23060077_lsu_axi_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .lsu_r_valid_i  (lsu_r_valid_i),
        .lsu_r_addr_i   (lsu_r_addr_i),
        .lsu_r_len_i    (lsu_r_len_i),
        .lsu_r_ready_o  (lsu_r_ready_o),
        .lsu_r_last_o   (lsu_r_last_o),
        .lsu_r_data_o   (lsu_r_data_o),
        .lsu_w_valid_i  (lsu_w_valid_i),
        .lsu_w_addr_i   (lsu_w_addr_i),
        .lsu_w_data_i   (lsu_w_data_i),
        .lsu_w_len_i    (lsu_w_len_i),
        .lsu_w_size_i   (lsu_w_size_i),
        .lsu_w_ready_o  (lsu_w_ready_o),
        .lsu_w_last_o   (lsu_w_last_o),
`ifdef YSYX_23060077_LSU_AXI_ERR_EN
        .lsu_bus_err_o  (lsu_bus_err_o),
        .lsu_err_addr_o (lsu_err_addr_o),
`endif
        .axi            (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // slave latency / response configuration
    int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = 2'b00;
    logic [1:0]  s_bresp = 2'b00;

    // Slave: each ready/valid answers after N cycles of the opposite side waiting.
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    always @(negedge clk) begin
        axi.rdata = s_rdata;
        axi.rresp = s_rresp;
        axi.rlast = 1'b1;
        axi.bresp = s_bresp;
        if (reset) begin
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            axi.arready = 1'b0; axi.rvalid = 1'b0; axi.awready = 1'b0;
            axi.wready  = 1'b0; axi.bvalid = 1'b0;
        end else begin
            if (axi.arvalid) begin axi.arready = (ar_cnt >= ar_wait); ar_cnt++; end
            else begin axi.arready = 1'b0; ar_cnt = 0; end
            if (axi.rready) begin axi.rvalid = (r_cnt >= r_wait); r_cnt++; end
            else begin axi.rvalid = 1'b0; r_cnt = 0; end
            if (axi.awvalid) begin axi.awready = (aw_cnt >= aw_wait); aw_cnt++; end
            else begin axi.awready = 1'b0; aw_cnt = 0; end
            if (axi.wvalid) begin axi.wready = (w_cnt >= w_wait); w_cnt++; end
            else begin axi.wready = 1'b0; w_cnt = 0; end
            if (axi.bready) begin axi.bvalid = (b_cnt >= b_wait); b_cnt++; end
            else begin axi.bvalid = 1'b0; b_cnt = 0; end
        end
    end

    // captured bus activity of the latest run
    logic [31:0] c_araddr, c_awaddr, c_wdata, c_rdata, c_err_addr;
    logic [2:0]  c_arsize, c_awsize;
    logic [1:0]  c_arburst, c_awburst;
    logic [3:0]  c_wstrb;
    logic        c_wlast, c_pr, c_prl, c_pw, c_pwl, c_err, prev_b;
    int          n_ar, n_aw, n_w, n_bent;

    // Raise the requested valid(s), watch the bus, return the cycle of the first pulse.
    task automatic run(input logic do_rd, input logic do_wr, output int cyc);
        n_ar = 0; n_aw = 0; n_w = 0; n_bent = 0; prev_b = 1'b0;
        c_err = 1'b0; c_err_addr = '0;
        cyc = -1;
        if (do_rd) lsu_r_valid_i = 1'b1;
        if (do_wr) lsu_w_valid_i = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (axi.arvalid) begin
                n_ar++; c_araddr = axi.araddr; c_arsize = axi.arsize; c_arburst = axi.arburst;
            end
            if (axi.awvalid) begin
                n_aw++; c_awaddr = axi.awaddr; c_awsize = axi.awsize; c_awburst = axi.awburst;
            end
            if (axi.wvalid) begin
                n_w++; c_wdata = axi.wdata; c_wstrb = axi.wstrb; c_wlast = axi.wlast;
            end
            if (axi.bready && !prev_b) n_bent++;
            prev_b = axi.bready;
            if (lsu_r_ready_o || lsu_w_ready_o) begin
                cyc   = i;
                c_pr  = lsu_r_ready_o; c_prl = lsu_r_last_o;
                c_pw  = lsu_w_ready_o; c_pwl = lsu_w_last_o;
                c_rdata = lsu_r_data_o;
`ifdef YSYX_23060077_LSU_AXI_ERR_EN
                c_err = lsu_bus_err_o; c_err_addr = lsu_err_addr_o;
`endif
                if (lsu_r_ready_o) lsu_r_valid_i = 1'b0;
                if (lsu_w_ready_o) lsu_w_valid_i = 1'b0;
                break;
            end
        end
    endtask

    task automatic check_pulse_gone(input string tag);
        @(negedge clk);
        check(tag, {30'd0, lsu_r_ready_o, lsu_w_ready_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    int cyc;

    initial begin
        reset = 1'b1;
        lsu_r_valid_i = 1'b0; lsu_r_addr_i = '0; lsu_r_len_i = '0;
        lsu_w_valid_i = 1'b0; lsu_w_addr_i = '0; lsu_w_data_i = '0;
        lsu_w_len_i = '0; lsu_w_size_i = '0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_valids", {27'd0, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 32'd0);
        check("rst_lsu", {29'd0, lsu_r_ready_o, lsu_w_ready_o, axi.wlast}, 32'd0);
        check("rst_data", lsu_r_data_o | axi.araddr | axi.wdata | 32'(axi.wstrb), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // load word, zero wait
        s_rdata = 32'hDEAD_BEEF; lsu_r_addr_i = 32'h8000_0004;
        run(1'b1, 1'b0, cyc);
        check("ld0_cycle", 32'(cyc), 32'd3);
        check("ld0_araddr", c_araddr, 32'h8000_0004);
        check("ld0_arsize", 32'(c_arsize), 32'd2);
        check("ld0_arburst", 32'(c_arburst), 32'd1);
        check("ld0_data", c_rdata, 32'hDEAD_BEEF);
        check("ld0_last", {30'd0, c_pr, c_prl}, 32'd3);
`ifdef YSYX_23060077_LSU_AXI_ERR_EN
        check("ld0_noerr", 32'(c_err), 32'd0);
`endif
        check_pulse_gone("ld0_pulse_width");

        // misaligned load, arready delayed 2 cycles
        ar_wait = 2; s_rdata = 32'h1122_3344; lsu_r_addr_i = 32'h8000_0003;
        run(1'b1, 1'b0, cyc);
        check("ld1_cycle", 32'(cyc), 32'd5);
        check("ld1_araddr", c_araddr, 32'h8000_0000);
        check("ld1_data", c_rdata, 32'h0000_0011);
        check("ld1_ar_hold", 32'(n_ar), 32'd3);
        check_pulse_gone("ld1_pulse_width");
        ar_wait = 0;

        // store byte, wready 2 cycles after awready
        w_wait = 2;
        lsu_w_addr_i = 32'h8000_0002; lsu_w_data_i = 32'h0000_00AB; lsu_w_size_i = 3'd0;
        run(1'b0, 1'b1, cyc);
        check("stb_cycle", 32'(cyc), 32'd5);
        check("stb_awaddr", c_awaddr, 32'h8000_0000);
        check("stb_awsize", 32'(c_awsize), 32'd0);
        check("stb_awburst", 32'(c_awburst), 32'd1);
        check("stb_wdata", c_wdata, 32'h00AB_0000);
        check("stb_wstrb", 32'(c_wstrb), 32'h4);
        check("stb_wlast", 32'(c_wlast), 32'd1);
        check("stb_aw_cycles", 32'(n_aw), 32'd1);
        check("stb_w_cycles", 32'(n_w), 32'd3);
        check("stb_wresp_entries", 32'(n_bent), 32'd1);
        check("stb_last", {30'd0, c_pw, c_pwl}, 32'd3);
        check_pulse_gone("stb_pulse_width");
        w_wait = 0;

        // store half at offset 2
        lsu_w_addr_i = 32'h8000_0002; lsu_w_data_i = 32'h0000_1234; lsu_w_size_i = 3'd1;
        run(1'b0, 1'b1, cyc);
        check("sth_cycle", 32'(cyc), 32'd3);
        check("sth_wstrb", 32'(c_wstrb), 32'hC);
        check("sth_wdata", c_wdata, 32'h1234_0000);
        check("sth_awsize", 32'(c_awsize), 32'd1);
        @(negedge clk);

        // misaligned word store: strobe truncated, no split
        lsu_w_addr_i = 32'h8000_0001; lsu_w_data_i = 32'h1122_3344; lsu_w_size_i = 3'd2;
        run(1'b0, 1'b1, cyc);
        check("stw_wstrb", 32'(c_wstrb), 32'hE);
        check("stw_wdata", c_wdata, 32'h2233_4400);
        check("stw_single", 32'(n_aw), 32'd1);
        @(negedge clk);

        // oversized size code behaves as word
        lsu_w_addr_i = 32'h8000_0008; lsu_w_data_i = 32'hA5A5_5A5A; lsu_w_size_i = 3'd7;
        run(1'b0, 1'b1, cyc);
        check("st7_awsize", 32'(c_awsize), 32'd2);
        check("st7_wstrb", 32'(c_wstrb), 32'hF);
        @(negedge clk);

        // simultaneous requests: read first, write after read pulse + IDLE
        s_rdata = 32'h0BAD_F00D; lsu_r_addr_i = 32'h8000_0020;
        lsu_w_addr_i = 32'h8000_0024; lsu_w_data_i = 32'h0000_0077; lsu_w_size_i = 3'd0;
        run(1'b1, 1'b1, cyc);
        check("both_rd_first", {30'd0, c_pr, c_pw}, 32'd2);
        check("both_rd_cycle", 32'(cyc), 32'd3);
        check("both_no_aw", 32'(n_aw), 32'd0);
        run(1'b0, 1'b1, cyc);
        check("both_wr_cycle", 32'(cyc), 32'd4);
        check("both_wr_awaddr", c_awaddr, 32'h8000_0024);
        check("both_wr_strb", 32'(c_wstrb), 32'h1);
        @(negedge clk);

        // reset while waiting in RDATA
        r_wait = 10; lsu_r_addr_i = 32'h8000_0008; lsu_r_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (axi.rready) break;
        end
        check("rst_mid_rready_seen", 32'(axi.rready), 32'd1);
        lsu_r_valid_i = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_mid_valids", {28'd0, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid}, 32'd0);
        check("rst_mid_araddr", axi.araddr, 32'd0);
        check("rst_mid_lsu", {30'd0, lsu_r_ready_o, lsu_r_last_o}, 32'd0);
        @(negedge clk);
        reset = 1'b0; r_wait = 0;
        @(negedge clk);
        s_rdata = 32'hCAFE_F00D;
        run(1'b1, 1'b0, cyc);
        check("post_rst_cycle", 32'(cyc), 32'd3);
        check("post_rst_data", c_rdata, 32'hCAFE_F00D);
        @(negedge clk);

        // store with SLVERR response still completes
        s_bresp = 2'b10;
        lsu_w_addr_i = 32'h8000_0010; lsu_w_data_i = 32'h0000_0055; lsu_w_size_i = 3'd0;
        run(1'b0, 1'b1, cyc);
        check("err_cycle", 32'(cyc), 32'd3);
        check("err_done", {30'd0, c_pw, c_pwl}, 32'd3);
`ifdef YSYX_23060077_LSU_AXI_ERR_EN
        check("err_pulse", 32'(c_err), 32'd1);
        check("err_addr", c_err_addr, 32'h8000_0010);
        @(negedge clk);
        check("err_pulse_gone", 32'(lsu_bus_err_o), 32'd0);
        check("err_addr_hold", lsu_err_addr_o, 32'h8000_0010);
`else
        @(negedge clk);
`endif
        s_bresp = 2'b00;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
